// File: rtl/agc_gain_ctrl.sv
// agc_gain_ctrl: auto-gain control loop placed after the luma clipper.
//   It averages the clipper's PRODUCT stream over 2^WINDOW_LOG2 valid samples.
//   Then it moves GAIN one step toward TARGET, with a dead band of +/-HYST.
//   After each gain change it discards SETTLE_CNT valid samples, because those
//   samples were produced with the old gain.
//
// Optional feature macro: AGC_FREEZE_EN
//   When defined, a FREEZE input is added. FREEZE=1 during DECIDE holds GAIN
//   and skips SETTLE. AVG and WINDOW_DONE still update as usual.
//
// Ports:
//   CLK            in   1   rising-edge clock
//   RST            in   1   synchronous reset, active-high
//   PRODUCT_VALID  in   1   PRODUCT carries a valid sample this cycle
//   PRODUCT        in  12   clipped luma*gain sample
//   GAIN           out  4   current gain, fed back to the clipper
//   AVG            out 12   average of the last completed window
//   WINDOW_DONE    out  1   one-cycle pulse after every window
//   GAIN_UPDATE    out  1   one-cycle pulse when GAIN changed
//   FREEZE         in   1   (AGC_FREEZE_EN only) hold GAIN at the next decision
module agc_gain_ctrl #(
  parameter int          WINDOW_LOG2 = 4,
  parameter logic [11:0] TARGET      = 12'd240,
  parameter logic [11:0] HYST        = 12'd16,
  parameter logic [3:0]  GAIN_INIT   = 4'd1,
  parameter int          SETTLE_CNT  = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        PRODUCT_VALID,
  input  logic [11:0] PRODUCT,
  output logic [3:0]  GAIN,
  output logic [11:0] AVG,
  output logic        WINDOW_DONE,
  output logic        GAIN_UPDATE
`ifdef AGC_FREEZE_EN
  ,
  input  logic        FREEZE
`endif
);

  localparam int ACC_W = 12 + WINDOW_LOG2;
  localparam int CNT_W = WINDOW_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'((1 << WINDOW_LOG2) - 1);
  localparam logic [3:0]       SETTLE_LD = 4'(SETTLE_CNT);

  function automatic logic [11:0] sat_sub12(input logic [11:0] a, input logic [11:0] b);
    return (a >= b) ? (a - b) : 12'd0;
  endfunction

  function automatic logic [11:0] sat_add12(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[12] ? 12'hFFF : s[11:0];
  endfunction

  localparam logic [11:0] THR_LO = sat_sub12(TARGET, HYST);
  localparam logic [11:0] THR_HI = sat_add12(TARGET, HYST);

  typedef enum logic [1:0] {S_ACCUM, S_DECIDE, S_SETTLE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [3:0]         r_settle;
  logic [3:0]         r_gain;
  logic [11:0]        r_avg;
  logic               r_wd;
  logic               r_gu;
  logic [11:0]        w_avg;
  logic               w_freeze;
  logic               w_up;
  logic               w_dn;

`ifdef AGC_FREEZE_EN
  assign w_freeze = FREEZE;
`else
  assign w_freeze = 1'b0;
`endif

  // A truncating divide by the window length is simply the top 12 bits.
  assign w_avg = r_acc[ACC_W-1:WINDOW_LOG2];
  // avg equal to THR_LO or THR_HI is inside the dead band.
  assign w_up  = (w_avg < THR_LO) && (r_gain != 4'd15) && !w_freeze;
  assign w_dn  = (w_avg > THR_HI) && (r_gain != 4'd0)  && !w_freeze;

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_ACCUM;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_ACCUM:  if (PRODUCT_VALID && (r_cnt == LAST_CNT)) w_next = S_DECIDE;
      S_DECIDE: w_next = ((w_up || w_dn) && (SETTLE_LD != 4'd0)) ? S_SETTLE : S_ACCUM;
      // r_settle is at least 1 on entry, so the sample seen at 1 is the last discard.
      S_SETTLE: if (PRODUCT_VALID && (r_settle == 4'd1)) w_next = S_ACCUM;
      default:  w_next = S_ACCUM;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_acc    <= '0;
      r_cnt    <= '0;
      r_settle <= 4'd0;
      r_gain   <= GAIN_INIT;
      r_avg    <= 12'd0;
      r_wd     <= 1'b0;
      r_gu     <= 1'b0;
    end else begin
      r_wd <= 1'b0;
      r_gu <= 1'b0;
      case (r_state)
        S_ACCUM: begin
          if (PRODUCT_VALID) begin
            r_acc <= r_acc + ACC_W'(PRODUCT);
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DECIDE: begin
          // Any sample presented in this cycle is dropped.
          r_avg    <= w_avg;
          r_wd     <= 1'b1;
          r_acc    <= '0;
          r_cnt    <= '0;
          r_settle <= SETTLE_LD;
          if (w_up) begin
            r_gain <= r_gain + 4'd1;
            r_gu   <= 1'b1;
          end else if (w_dn) begin
            r_gain <= r_gain - 4'd1;
            r_gu   <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (PRODUCT_VALID) r_settle <= r_settle - 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign GAIN        = r_gain;
  assign AVG         = r_avg;
  assign WINDOW_DONE = r_wd;
  assign GAIN_UPDATE = r_gu;

endmodule

// File: tb/tb_agc_gain_ctrl.sv
// Directed bench for agc_gain_ctrl using the default parameters.
module tb_agc_gain_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        PRODUCT_VALID = 1'b0;
  logic [11:0] PRODUCT = 12'd0;
  logic [3:0]  GAIN;
  logic [11:0] AVG;
  logic        WINDOW_DONE;
  logic        GAIN_UPDATE;
`ifdef AGC_FREEZE_EN
  logic        FREEZE = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Outputs captured around the end of a window.
  logic        ob_wd_e, ob_wd, ob_gu, ob_wd2, ob_gu2;
  logic [3:0]  ob_gain_e, ob_gain;
  logic [11:0] ob_avg;

  agc_gain_ctrl dut (
    .CLK(CLK), .RST(RST), .PRODUCT_VALID(PRODUCT_VALID), .PRODUCT(PRODUCT),
    .GAIN(GAIN), .AVG(AVG), .WINDOW_DONE(WINDOW_DONE), .GAIN_UPDATE(GAIN_UPDATE)
`ifdef AGC_FREEZE_EN
    , .FREEZE(FREEZE)
`endif
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [11:0] p);
    @(negedge CLK);
    PRODUCT_VALID = v;
    PRODUCT       = p;
  endtask

  // 16 valid samples alternating a (even) / b (odd), optional idle gap after each.
  // The last sample lands at edge E; outputs are captured after E, E+1 and E+2.
  // dval presents a 4095 sample during the DECIDE cycle.
  task automatic feed_window(input logic [11:0] a, input logic [11:0] b,
                             input bit gaps, input bit dval);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, (i % 2 == 0) ? a : b);
      if (gaps && i != 15) drive(1'b0, 12'd0);
    end
    @(posedge CLK); #1;
    ob_wd_e = WINDOW_DONE; ob_gain_e = GAIN;
    drive(dval, 12'hFFF);
    @(posedge CLK); #1;
    ob_avg = AVG; ob_gain = GAIN; ob_wd = WINDOW_DONE; ob_gu = GAIN_UPDATE;
    drive(1'b0, 12'd0);
    @(posedge CLK); #1;
    ob_wd2 = WINDOW_DONE; ob_gu2 = GAIN_UPDATE;
  endtask

  task automatic discard2();
    drive(1'b1, 12'hFFF);
    drive(1'b1, 12'hFFF);
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    n_checks++; if (GAIN !== 4'd1) $display("FAIL reset_gain got=%0d exp=1", GAIN); else n_pass++;
    n_checks++; if (AVG !== 12'd0) $display("FAIL reset_avg got=%0d exp=0", AVG); else n_pass++;
    n_checks++; if (WINDOW_DONE !== 1'b0) $display("FAIL reset_wd got=%b exp=0", WINDOW_DONE); else n_pass++;
    n_checks++; if (GAIN_UPDATE !== 1'b0) $display("FAIL reset_gu got=%b exp=0", GAIN_UPDATE); else n_pass++;
    @(negedge CLK); RST = 1'b0;
  endtask

  task automatic test_gain_up();
    feed_window(12'd100, 12'd100, 1'b0, 1'b0);
    n_checks++; if (ob_wd_e !== 1'b0) $display("FAIL up_wd_early got=%b exp=0", ob_wd_e); else n_pass++;
    n_checks++; if (ob_gain_e !== 4'd1) $display("FAIL up_gain_early got=%0d exp=1", ob_gain_e); else n_pass++;
    n_checks++; if (ob_avg !== 12'd100) $display("FAIL up_avg got=%0d exp=100", ob_avg); else n_pass++;
    n_checks++; if (ob_gain !== 4'd2) $display("FAIL up_gain got=%0d exp=2", ob_gain); else n_pass++;
    n_checks++; if (ob_wd !== 1'b1) $display("FAIL up_wd got=%b exp=1", ob_wd); else n_pass++;
    n_checks++; if (ob_gu !== 1'b1) $display("FAIL up_gu got=%b exp=1", ob_gu); else n_pass++;
    n_checks++; if (ob_wd2 !== 1'b0) $display("FAIL up_wd_drop got=%b exp=0", ob_wd2); else n_pass++;
    n_checks++; if (ob_gu2 !== 1'b0) $display("FAIL up_gu_drop got=%b exp=0", ob_gu2); else n_pass++;
    discard2();
  endtask

  // The two 4095 samples just sent must be discarded, else AVG would not be 400.
  task automatic test_gaps_down();
    feed_window(12'd400, 12'd400, 1'b1, 1'b0);
    n_checks++; if (ob_avg !== 12'd400) $display("FAIL gap_avg got=%0d exp=400", ob_avg); else n_pass++;
    n_checks++; if (ob_gain !== 4'd1) $display("FAIL gap_gain got=%0d exp=1", ob_gain); else n_pass++;
    n_checks++; if (ob_wd !== 1'b1) $display("FAIL gap_wd got=%b exp=1", ob_wd); else n_pass++;
    n_checks++; if (ob_gu !== 1'b1) $display("FAIL gap_gu got=%b exp=1", ob_gu); else n_pass++;
    discard2();
  endtask

  task automatic test_dead_band();
    feed_window(12'd224, 12'd256, 1'b0, 1'b1);
    n_checks++; if (ob_avg !== 12'd240) $display("FAIL band_avg got=%0d exp=240", ob_avg); else n_pass++;
    n_checks++; if (ob_gain !== 4'd1) $display("FAIL band_gain got=%0d exp=1", ob_gain); else n_pass++;
    n_checks++; if (ob_wd !== 1'b1) $display("FAIL band_wd got=%b exp=1", ob_wd); else n_pass++;
    n_checks++; if (ob_gu !== 1'b0) $display("FAIL band_gu got=%b exp=0", ob_gu); else n_pass++;
    feed_window(12'd224, 12'd224, 1'b0, 1'b0);
    n_checks++; if (ob_avg !== 12'd224) $display("FAIL lo_avg got=%0d exp=224", ob_avg); else n_pass++;
    n_checks++; if (ob_gain !== 4'd1) $display("FAIL lo_gain got=%0d exp=1", ob_gain); else n_pass++;
    n_checks++; if (ob_wd !== 1'b1) $display("FAIL lo_wd got=%b exp=1", ob_wd); else n_pass++;
    n_checks++; if (ob_gu !== 1'b0) $display("FAIL lo_gu got=%b exp=0", ob_gu); else n_pass++;
    feed_window(12'd256, 12'd256, 1'b0, 1'b0);
    n_checks++; if (ob_gain !== 4'd1) $display("FAIL hi_gain got=%0d exp=1", ob_gain); else n_pass++;
    n_checks++; if (ob_gu !== 1'b0) $display("FAIL hi_gu got=%b exp=0", ob_gu); else n_pass++;
    feed_window(12'd257, 12'd257, 1'b0, 1'b0);
    n_checks++; if (ob_gain !== 4'd0) $display("FAIL above_hi_gain got=%0d exp=0", ob_gain); else n_pass++;
    n_checks++; if (ob_gu !== 1'b1) $display("FAIL above_hi_gu got=%b exp=1", ob_gu); else n_pass++;
    discard2();
  endtask

  task automatic test_saturation();
    feed_window(12'hFFF, 12'hFFF, 1'b0, 1'b0);
    n_checks++; if (ob_avg !== 12'd4095) $display("FAIL min_avg got=%0d exp=4095", ob_avg); else n_pass++;
    n_checks++; if (ob_gain !== 4'd0) $display("FAIL min_gain got=%0d exp=0", ob_gain); else n_pass++;
    n_checks++; if (ob_gu !== 1'b0) $display("FAIL min_gu got=%b exp=0", ob_gu); else n_pass++;
    for (int k = 0; k < 15; k++) begin
      feed_window(12'd0, 12'd0, 1'b0, 1'b0);
      n_checks++; if (ob_wd !== 1'b1) $display("FAIL ramp_wd step=%0d got=%b exp=1", k, ob_wd); else n_pass++;
      n_checks++; if (ob_gain !== 4'(k + 1)) $display("FAIL ramp_gain step=%0d got=%0d exp=%0d", k, ob_gain, k + 1); else n_pass++;
      discard2();
    end
    feed_window(12'd0, 12'd0, 1'b0, 1'b0);
    n_checks++; if (ob_gain !== 4'd15) $display("FAIL max_gain got=%0d exp=15", ob_gain); else n_pass++;
    n_checks++; if (ob_gu !== 1'b0) $display("FAIL max_gu got=%b exp=0", ob_gu); else n_pass++;
    // No SETTLE after a held gain: the next 16 samples must close a window on time.
    feed_window(12'd240, 12'd240, 1'b0, 1'b0);
    n_checks++; if (ob_wd !== 1'b1) $display("FAIL max_nosettle_wd got=%b exp=1", ob_wd); else n_pass++;
    n_checks++; if (ob_avg !== 12'd240) $display("FAIL max_nosettle_avg got=%0d exp=240", ob_avg); else n_pass++;
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 7; i++) drive(1'b1, 12'hFFF);
    @(negedge CLK); PRODUCT_VALID = 1'b0; RST = 1'b1;
    @(posedge CLK); #1;
    n_checks++; if (GAIN !== 4'd1) $display("FAIL mid_rst_gain got=%0d exp=1", GAIN); else n_pass++;
    n_checks++; if (AVG !== 12'd0) $display("FAIL mid_rst_avg got=%0d exp=0", AVG); else n_pass++;
    @(negedge CLK); RST = 1'b0;
    feed_window(12'd100, 12'd100, 1'b0, 1'b0);
    n_checks++; if (ob_avg !== 12'd100) $display("FAIL mid_rst_win_avg got=%0d exp=100", ob_avg); else n_pass++;
    n_checks++; if (ob_gain !== 4'd2) $display("FAIL mid_rst_win_gain got=%0d exp=2", ob_gain); else n_pass++;
    discard2();
  endtask

`ifdef AGC_FREEZE_EN
  task automatic test_freeze();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0; FREEZE = 1'b1;
    feed_window(12'd100, 12'd100, 1'b0, 1'b0);
    n_checks++; if (ob_avg !== 12'd100) $display("FAIL frz_avg got=%0d exp=100", ob_avg); else n_pass++;
    n_checks++; if (ob_wd !== 1'b1) $display("FAIL frz_wd got=%b exp=1", ob_wd); else n_pass++;
    n_checks++; if (ob_gain !== 4'd1) $display("FAIL frz_gain got=%0d exp=1", ob_gain); else n_pass++;
    n_checks++; if (ob_gu !== 1'b0) $display("FAIL frz_gu got=%b exp=0", ob_gu); else n_pass++;
    FREEZE = 1'b0;
    feed_window(12'd100, 12'd100, 1'b0, 1'b0);
    n_checks++; if (ob_wd !== 1'b1) $display("FAIL frz_nosettle_wd got=%b exp=1", ob_wd); else n_pass++;
    n_checks++; if (ob_gain !== 4'd2) $display("FAIL frz_after_gain got=%0d exp=2", ob_gain); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_gain_up();
    test_gaps_down();
    test_dead_band();
    test_saturation();
    test_reset_mid_window();
`ifdef AGC_FREEZE_EN
    test_freeze();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
